// File: rtl/pool_pkg.sv
// Shared definitions for the pooling datapath: mode encodings,
// accumulator sizing and N-bit saturation.
package pool_pkg;

  typedef enum logic {
    POOL_AVG = 1'b0,
    POOL_MAX = 1'b1
  } pool_mode_e;

  // Accumulator must hold the sum of P*P sign-extended N-bit pixels.
  function automatic int acc_width(input int n, input int p);
    return n + $clog2(p * p);
  endfunction

  // Clamp a signed value into the signed n-bit range.
  function automatic logic signed [63:0] sat_to_n(input logic signed [63:0] v, input int n);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (n - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (n - 1));
    if (v > hi) begin
      return hi;
    end else if (v < lo) begin
      return lo;
    end
    return v;
  endfunction

endpackage

// File: rtl/pool_alu.sv
// Combinational pooling ALU: folds one pixel into a partial window value
// (max or add) and scales a completed sum by (1/P)^2 with saturation.
module pool_alu
  import pool_pkg::*;
#(
  parameter int          N         = 16,
  parameter int          Q         = 12,
  parameter int          A         = 20,
  parameter logic [N-1:0] P_SQR_INV = 16'h01C7
) (
  input  logic                mode,
  input  logic                base_valid,
  input  logic signed [A-1:0] base,
  input  logic signed [N-1:0] x,
  output logic signed [A-1:0] comb,
  output logic signed [N-1:0] scaled
);

  logic signed [A-1:0]   x_ext;
  logic signed [A+N-1:0] comb_ext;
  logic signed [A+N-1:0] inv_ext;
  logic signed [A+N-1:0] prod;

  assign x_ext = A'(x);

  // Combine the incoming pixel with the partial window value, if any.
  always_comb begin
    comb = x_ext;
    if (base_valid) begin
      if (mode == POOL_MAX) begin
        comb = (base > x_ext) ? base : x_ext;
      end else begin
        comb = base + x_ext;
      end
    end
  end

  // The scale factor is a positive Q-format constant, so it is zero-extended;
  // the arithmetic shift makes the division round toward minus infinity.
  assign comb_ext = {{N{comb[A-1]}}, comb};
  assign inv_ext  = {{A{1'b0}}, P_SQR_INV};
  assign prod     = comb_ext * inv_ext;
  assign scaled   = N'(sat_to_n(64'(prod >>> Q), N));

endmodule

// File: rtl/pooler_stream.sv
// Streaming P x P non-overlapping pooler over an M x M raster-order map,
// with run-time max/average selection per map and a 1-entry output register.
module pooler_stream
  import pool_pkg::*;
#(
  parameter int           M         = 12,
  parameter int           P         = 3,
  parameter int           N         = 16,
  parameter int           Q         = 12,
  parameter logic [N-1:0] P_SQR_INV = 16'h01C7
) (
  input  logic         clk,
  input  logic         master_rst,
  input  logic         clr,
  input  logic         mode,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_data,
  output logic         out_last,
  output logic         busy
);

  localparam int A  = acc_width(N, P);
  localparam int G  = M / P;
  localparam int CW = (M > 1) ? $clog2(M) : 1;
  localparam int PW = (P > 1) ? $clog2(P) : 1;
  localparam int GW = (G > 1) ? $clog2(G) : 1;

  localparam logic [CW-1:0] COL_LAST = CW'(M - 1);
  localparam logic [PW-1:0] WIN_LAST = PW'(P - 1);

  generate
    if ((M % P) != 0) begin : g_bad_size
      $fatal(1, "pooler_stream: M must be a multiple of P");
    end
  endgenerate

  logic [CW-1:0]       col_reg;
  logic [CW-1:0]       row_reg;
  logic [PW-1:0]       wcol_reg;
  logic [PW-1:0]       wrow_reg;
  logic [GW-1:0]       g_reg;
  logic                mode_reg;
  logic signed [A-1:0] acc_reg;
  logic                out_valid_reg;
  logic                out_last_reg;
  logic [N-1:0]        out_data_reg;

  logic signed [A-1:0] lb_q [G];

  logic                accept;
  logic                first_pix;
  logic                cur_mode;
  logic                col_last;
  logic                row_last;
  logic                wcol_last;
  logic                wrow_last;
  logic                win_done;
  logic                lb_we;
  logic                base_valid;
  logic signed [A-1:0] base;
  logic signed [A-1:0] comb;
  logic signed [N-1:0] scaled;

  // The output register is only refilled when it is empty or being drained.
  assign in_ready  = !out_valid_reg || out_ready;
  assign accept    = in_valid && in_ready;

  assign first_pix = (row_reg == '0) && (col_reg == '0);
  assign cur_mode  = first_pix ? mode : mode_reg;
  assign col_last  = (col_reg == COL_LAST);
  assign row_last  = (row_reg == COL_LAST);
  assign wcol_last = (wcol_reg == WIN_LAST);
  assign wrow_last = (wrow_reg == WIN_LAST);
  assign win_done  = accept && wcol_last && wrow_last;
  assign lb_we     = accept && wcol_last && !wrow_last;

  // Pick the partial value the pixel extends: same-row run, or the column
  // group's partial from the rows above; the window's first pixel has none.
  always_comb begin
    base_valid = 1'b0;
    base       = acc_reg;
    if (wcol_reg != '0) begin
      base_valid = 1'b1;
      base       = acc_reg;
    end else if (wrow_reg != '0) begin
      base_valid = 1'b1;
      base       = lb_q[g_reg];
    end
  end

  pool_alu #(
    .N         (N),
    .Q         (Q),
    .A         (A),
    .P_SQR_INV (P_SQR_INV)
  ) u_alu (
    .mode       (cur_mode),
    .base_valid (base_valid),
    .base       (base),
    .x          (in_data),
    .comb       (comb),
    .scaled     (scaled)
  );

  // One partial-window register per column group; contents need no reset
  // because every window starts fresh on its first pixel.
  generate
    for (genvar gi = 0; gi < G; gi++) begin : g_lb
      logic signed [A-1:0] entry_reg;

      // Store the group's partial at the end of each non-final window row.
      always_ff @(posedge clk) begin
        if (lb_we && (g_reg == GW'(gi))) begin
          entry_reg <= comb;
        end
      end

      assign lb_q[gi] = entry_reg;
    end
  endgenerate

  // Raster position, window-relative counters, mode latch and row accumulator.
  always_ff @(posedge clk or negedge master_rst) begin
    if (!master_rst) begin
      col_reg  <= '0;
      row_reg  <= '0;
      wcol_reg <= '0;
      wrow_reg <= '0;
      g_reg    <= '0;
      mode_reg <= 1'b0;
      acc_reg  <= '0;
    end else if (clr) begin
      col_reg  <= '0;
      row_reg  <= '0;
      wcol_reg <= '0;
      wrow_reg <= '0;
      g_reg    <= '0;
      mode_reg <= 1'b0;
      acc_reg  <= '0;
    end else if (accept) begin
      if (first_pix) begin
        mode_reg <= mode;
      end
      if (!wcol_last) begin
        acc_reg <= comb;
      end
      wcol_reg <= wcol_last ? '0 : wcol_reg + 1'b1;
      if (col_last) begin
        col_reg  <= '0;
        g_reg    <= '0;
        row_reg  <= row_last ? '0 : row_reg + 1'b1;
        wrow_reg <= wrow_last ? '0 : wrow_reg + 1'b1;
      end else begin
        col_reg <= col_reg + 1'b1;
        if (wcol_last) begin
          g_reg <= g_reg + 1'b1;
        end
      end
    end
  end

  // Output register: a completing window wins over a same-cycle drain.
  always_ff @(posedge clk or negedge master_rst) begin
    if (!master_rst) begin
      out_valid_reg <= 1'b0;
      out_last_reg  <= 1'b0;
      out_data_reg  <= '0;
    end else if (clr) begin
      out_valid_reg <= 1'b0;
      out_last_reg  <= 1'b0;
      out_data_reg  <= '0;
    end else if (win_done) begin
      out_valid_reg <= 1'b1;
      out_last_reg  <= row_last && col_last;
      out_data_reg  <= (cur_mode == POOL_MAX) ? comb[N-1:0] : scaled;
    end else if (out_ready) begin
      out_valid_reg <= 1'b0;
      out_last_reg  <= 1'b0;
    end
  end

  assign out_valid = out_valid_reg;
  assign out_last  = out_last_reg;
  assign out_data  = out_data_reg;
  assign busy      = (col_reg != '0) || (row_reg != '0) || out_valid_reg;

endmodule

// File: tb/tb_pooler_stream.sv
// Scoreboard bench for pooler_stream (M=4, P=2): a window-level reference
// model fills the expected queue as stimulus is issued; a separate monitor
// pops and compares every output handshake.
`timescale 1ns/1ps
module tb_pooler_stream;

  localparam int          TM   = 4;
  localparam int          TP   = 2;
  localparam int          TQ   = 12;
  localparam int          NPIX = TM * TM;
  localparam int          GS   = TM / TP;
  localparam int          NWIN = GS * GS;
  localparam logic [15:0] TINV = 16'h0400;

  typedef struct packed {
    logic [15:0] data;
    logic        last;
  } exp_t;

  logic        clk        = 1'b0;
  logic        master_rst = 1'b1;
  logic        clr        = 1'b0;
  logic        mode       = 1'b0;
  logic        in_valid   = 1'b0;
  logic        in_ready;
  logic [15:0] in_data    = '0;
  logic        out_valid;
  logic        out_ready  = 1'b1;
  logic [15:0] out_data;
  logic        out_last;
  logic        busy;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   txn = 0;
  bit   gaps_on = 1'b0;
  bit   ready_random = 1'b0;
  bit   stall_req = 1'b0;
  int   first_accept = 0;
  int   last_accept = 0;

  pooler_stream #(
    .M         (TM),
    .P         (TP),
    .N         (16),
    .Q         (TQ),
    .P_SQR_INV (TINV)
  ) dut (
    .clk        (clk),
    .master_rst (master_rst),
    .clr        (clr),
    .mode       (mode),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: each window's max, or floor(sum * (1/P)^2) clamped to 16 bits.
  function automatic void model_map(input logic [15:0] px [NPIX], input logic md,
                                    output exp_t res [NWIN]);
    for (int w = 0; w < NWIN; w++) begin
      int     wr = w / GS;
      int     wc = w % GS;
      longint sum = 0;
      longint mx = 0;
      longint v;
      longint r;
      for (int i = 0; i < TP; i++) begin
        for (int j = 0; j < TP; j++) begin
          v = longint'($signed(px[(wr * TP + i) * TM + wc * TP + j]));
          sum += v;
          if ((i == 0 && j == 0) || v > mx) mx = v;
        end
      end
      if (md) begin
        r = mx;
      end else begin
        r = (sum * longint'(TINV)) >>> TQ;
        if (r > 32767) r = 32767;
        if (r < -32768) r = -32768;
      end
      res[w].data = r[15:0];
      res[w].last = (w == NWIN - 1);
    end
  endfunction

  function automatic void make_ramp(output logic [15:0] px [NPIX], input bit neg);
    for (int k = 0; k < NPIX; k++) begin
      px[k] = neg ? 16'(-(k * 256)) : 16'(k * 256);
    end
  endfunction

  task automatic send_pixel(input logic [15:0] d, input logic md);
    int budget = 0;
    bit done = 1'b0;
    while (!done) begin
      @(negedge clk);
      if (gaps_on && $urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
      end else begin
        in_valid = 1'b1;
        in_data  = d;
        mode     = md;
        #1;
        if (in_ready) begin
          done = 1'b1;
        end else begin
          budget++;
          if (budget > 200) begin
            checks++;
            errors++;
            $display("FAIL in_ready_timeout: in_ready=%b for %0d cycles, required 1", in_ready, budget);
            done = 1'b1;
          end
        end
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Drives one map; abort_at >= 0 stops before that pixel, toggle_at > 0
  // flips the mode input from that pixel onward (it must be ignored).
  task automatic send_map(input logic [15:0] px [NPIX], input logic md,
                          input int toggle_at, input int abort_at);
    exp_t res [NWIN];
    model_map(px, md, res);
    for (int k = 0; k < NPIX; k++) begin
      int   r = k / TM;
      int   c = k % TM;
      logic mk;
      if (k == abort_at) return;
      mk = (toggle_at > 0 && k >= toggle_at) ? ~md : md;
      send_pixel(px[k], mk);
      if (k == 0) first_accept = cyc;
      last_accept = cyc;
      if ((r % TP == TP - 1) && (c % TP == TP - 1)) begin
        sb.push_back(res[(r / TP) * GS + c / TP]);
        checks++;
        if (out_valid !== 1'b1) begin
          errors++;
          $display("FAIL latency: pixel %0d out_valid=%b one cycle after window end, required 1", k, out_valid);
        end
      end
    end
  endtask

  task automatic drain();
    int budget = 0;
    while (sb.size() != 0 && budget < 200) begin
      @(negedge clk);
      budget++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d results outstanding, required 0", sb.size());
      sb.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic abort_test(input bit use_rst);
    logic [15:0] px [NPIX];
    make_ramp(px, 1'b0);
    send_map(px, 1'b1, 0, 9);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_mid_map: busy=%b, required 1", busy);
    end
    @(negedge clk);
    if (use_rst) master_rst = 1'b0;
    else clr = 1'b1;
    sb.delete();
    if (use_rst) begin
      #1;
      checks++;
      if ({out_valid, out_last, busy, out_data} !== 19'd0) begin
        errors++;
        $display("FAIL async_reset: valid=%b last=%b busy=%b data=%h, required all 0",
                 out_valid, out_last, busy, out_data);
      end
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({out_valid, out_last, busy, out_data} !== 19'd0) begin
      errors++;
      $display("FAIL %s_state: valid=%b last=%b busy=%b data=%h, required all 0",
               use_rst ? "reset" : "clr", out_valid, out_last, busy, out_data);
    end
    @(negedge clk);
    master_rst = 1'b1;
    clr = 1'b0;
    send_map(px, 1'b1, 0, -1);
    drain();
  endtask

  // Downstream ready: scripted 5-cycle stall on demand, else steady or random.
  initial begin
    int stall_left = 0;
    forever begin
      @(negedge clk);
      if (stall_req && out_valid) begin
        stall_left = 5;
        stall_req  = 1'b0;
      end
      if (stall_left > 0) begin
        out_ready = 1'b0;
        stall_left--;
      end else begin
        out_ready = ready_random ? ($urandom_range(0, 2) != 0) : 1'b1;
      end
    end
  end

  // Monitor: compare each handshake against the queue; a stalled result
  // must hold its data and block the input.
  initial begin
    bit          prev_stall = 1'b0;
    logic [15:0] held = '0;
    exp_t        e;
    forever begin
      @(negedge clk);
      #2;
      if (!master_rst || clr) begin
        prev_stall = 1'b0;
        continue;
      end
      if (prev_stall) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== held) begin
          errors++;
          $display("FAIL hold: valid=%b data=%h, required 1 and %h", out_valid, out_data, held);
        end
      end
      if (out_valid && !out_ready) begin
        checks++;
        if (in_ready !== 1'b0) begin
          errors++;
          $display("FAIL in_ready_stall: in_ready=%b, required 0", in_ready);
        end
        prev_stall = 1'b1;
        held = out_data;
      end else begin
        prev_stall = 1'b0;
      end
      if (out_valid && out_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_result: data=%h last=%b, required none", out_data, out_last);
        end else begin
          e = sb.pop_front();
          txn++;
          $display("txn %0d: data=%h last=%b (expect %h/%b)", txn, out_data, out_last, e.data, e.last);
          if (out_data !== e.data || out_last !== e.last) begin
            errors++;
            $display("FAIL result: data=%h last=%b, required %h last=%b", out_data, out_last, e.data, e.last);
          end
        end
      end
    end
  end

  initial begin
    logic [15:0] px [NPIX];
    int          map_a_last;
    #1 master_rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({out_valid, out_last, busy, out_data} !== 19'd0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_state: valid=%b last=%b busy=%b data=%h in_ready=%b, required 0/0/0/0000/1",
               out_valid, out_last, busy, out_data, in_ready);
    end
    master_rst = 1'b1;

    make_ramp(px, 1'b0);
    send_map(px, 1'b1, 0, -1);
    drain();
    send_map(px, 1'b0, 0, -1);
    drain();

    make_ramp(px, 1'b1);
    send_map(px, 1'b1, 0, -1);
    drain();

    make_ramp(px, 1'b0);
    stall_req = 1'b1;
    send_map(px, 1'b1, 0, -1);
    drain();

    send_map(px, 1'b1, 7, -1);
    drain();
    send_map(px, 1'b1, 3, -1);
    map_a_last = last_accept;
    send_map(px, 1'b0, 5, -1);
    checks++;
    if (first_accept - map_a_last != 1) begin
      errors++;
      $display("FAIL back_to_back: gap=%0d cycles, required 1", first_accept - map_a_last);
    end
    drain();

    abort_test(1'b1);
    abort_test(1'b0);

    gaps_on = 1'b1;
    ready_random = 1'b1;
    for (int m = 0; m < 10; m++) begin
      for (int k = 0; k < NPIX; k++) begin
        if ($urandom_range(0, 3) == 0) px[k] = $urandom_range(0, 1) ? 16'h8000 : 16'h7FFF;
        else px[k] = 16'($urandom);
      end
      send_map(px, 1'($urandom_range(0, 1)), $urandom_range(1, NPIX - 1), -1);
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
